seq_restoring_divider: RTL

//  Multi-cycle unsigned restoring divider; the inverse of the lab's adder/multiplier datapath.

---
 rtl/seq_restoring_divider_pkg.sv | 25 ++
 rtl/seq_restoring_divider_if.sv | 33 +++
 rtl/seq_restoring_divider_cla_subtractor.sv | 63 ++++++
 rtl/seq_restoring_divider.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// ============================================================================
// Module   : seq_restoring_divider_pkg
// Purpose  : Shared FSM state encoding and counter-width helper for the
//            sequential restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_restoring_divider_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the iteration counter for a given operand width
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_restoring_divider_if.sv
// ============================================================================
// Module   : seq_restoring_divider_if
// Purpose  : Start/done handshake and operand/result bus of the divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_restoring_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_restoring_divider_cla_subtractor.sv
// ============================================================================
// Module   : seq_restoring_divider_cla_subtractor
// Purpose  : Combinational a - b as a + ~b + 1. Full 4-bit carry-lookahead
//            slices ripple their carries; any leftover bits (WIDTH mod 4)
//            form a short ripple tail. no_borrow_o is the final carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider_cla_subtractor #(
  parameter int WIDTH = 17
) (
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  output logic      [WIDTH-1:0] diff_o,
  output logic                  no_borrow_o
);

  localparam int NFULL = WIDTH / 4;
  localparam int TAIL  = WIDTH % 4;

  logic [WIDTH-1:0] b_inv;
  logic [NFULL:0]   carry;

  assign b_inv    = ~b_i;
  assign carry[0] = 1'b1;

  for (genvar s = 0; s < NFULL; s++) begin : g_slice
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p    = a_i[4*s +: 4] ^ b_inv[4*s +: 4];
    assign g    = a_i[4*s +: 4] & b_inv[4*s +: 4];
    assign c[0] = carry[s];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign diff_o[4*s +: 4] = p ^ c[3:0];
    assign carry[s+1]       = c[4];
  end

  if (TAIL > 0) begin : g_tail
    logic [TAIL:0] ct;
    assign ct[0] = carry[NFULL];
    for (genvar j = 0; j < TAIL; j++) begin : g_bit
      logic pb;
      assign pb                  = a_i[4*NFULL + j] ^ b_inv[4*NFULL + j];
      assign diff_o[4*NFULL + j] = pb ^ ct[j];
      assign ct[j+1]             = (a_i[4*NFULL + j] & b_inv[4*NFULL + j]) | (pb & ct[j]);
    end
    assign no_borrow_o = ct[TAIL];
  end else begin : g_no_tail
    assign no_borrow_o = carry[NFULL];
  end

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module   : seq_restoring_divider
// Purpose  : Multi-cycle unsigned restoring divider, one quotient bit per
//            clock, start/done handshake. Define SIGNED_DIV_EN to treat the
//            operands as two's complement (truncating division).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic             dbz_pend_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic [WIDTH:0]   trial_diff;
  logic             trial_nb, trial_take;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, res_quot, res_rem;
  logic             q_neg_d, r_neg_d;

`ifdef SIGNED_DIV_EN
  logic q_neg_q, r_neg_q;

  assign dvd_mag  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign q_neg_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
  assign r_neg_d  = bus.dividend[WIDTH-1];
  assign res_quot = q_neg_q ? -q_q : q_q;
  assign res_rem  = r_neg_q ? -r_q : r_q;
`else
  assign dvd_mag  = bus.dividend;
  assign dvs_mag  = bus.divisor;
  assign q_neg_d  = 1'b0;
  assign r_neg_d  = 1'b0;
  assign res_quot = q_q;
  assign res_rem  = r_q;
`endif

  // Trial subtraction of the divisor from the shifted partial remainder
  seq_restoring_divider_cla_subtractor #(.WIDTH(WIDTH + 1)) u_sub (
    .a_i         ({r_q, q_q[WIDTH-1]}),
    .b_i         ({1'b0, d_q}),
    .diff_o      (trial_diff),
    .no_borrow_o (trial_nb)
  );

  // The top difference bit is zero whenever the trial succeeds; folding it
  // in keeps the accept term exact over all WIDTH+1 bits.
  assign trial_take = trial_nb & ~trial_diff[WIDTH];

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

  // Control FSM, iteration datapath and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
`ifdef SIGNED_DIV_EN
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
            d_q    <= dvs_mag;
            cnt_q  <= CNT_W'(WIDTH - 1);
            if (bus.divisor == '0) begin
              // Results of a zero divide are loaded directly and presented
              // through the normal DONE path without sign fix-up.
              r_q        <= bus.dividend;
              q_q        <= '1;
              dbz_pend_q <= 1'b1;
`ifdef SIGNED_DIV_EN
              q_neg_q    <= 1'b0;
              r_neg_q    <= 1'b0;
`endif
              state_q    <= DONE;
            end else begin
              r_q        <= '0;
              q_q        <= dvd_mag;
              dbz_pend_q <= 1'b0;
`ifdef SIGNED_DIV_EN
              q_neg_q    <= q_neg_d;
              r_neg_q    <= r_neg_d;
`endif
              state_q    <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= trial_take ? trial_diff[WIDTH-1:0] : {r_q[WIDTH-2:0], q_q[WIDTH-1]};
          q_q   <= {q_q[WIDTH-2:0], trial_take};
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b1;
          quot_q  <= res_quot;
          rem_q   <= res_rem;
          dbz_q   <= dbz_pend_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifndef SIGNED_DIV_EN
  // Sign terms only matter in the signed build
  logic unused_sign;
  assign unused_sign = q_neg_d | r_neg_d;
`endif

endmodule

`default_nettype wire
